relu_row_sched: RTL

Row-serial scheduler for the ReLU embedding stage. It walks a MATRIX_SIZE_1 x MATRIX_SIZE_2 signed activation matrix held in an external row buffer and issues one row read at a time. It applies ReLU to each returned row and presents the result downstream on a valid/ready interface. It sits between the embedding-output buffer and the next layer's input loader, and replaces a full-matrix combinational ReLU with a sequenced one.

---
 rtl/relu_row_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/relu_row_sched.sv
// Row-serial ReLU scheduler: fetches one row per pass step from an external buffer, clamps x<=0 to 0, streams rows out.
// Latency: start -> first rd_en 1 cycle, rd_en -> out_valid 2 cycles; 3 cycles per row plus downstream stall cycles.
// Backpressure: SEND holds out_data/out_row until out_ready; no new read is issued while a row is waiting downstream.
// Optional RELU_ROW_SCHED_ZCNT_EN builds a per-pass counter of clamped elements; otherwise zero_cnt is tied to 0.
module relu_row_sched #(
    parameter int  DATA_WIDTH    = 8,
    parameter int  MATRIX_SIZE_1 = 15,
    parameter int  MATRIX_SIZE_2 = 16,
    localparam int RW            = $clog2(MATRIX_SIZE_1),
    localparam int ZW            = $clog2(MATRIX_SIZE_1 * MATRIX_SIZE_2 + 1),
    localparam int ROW_W         = MATRIX_SIZE_2 * DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [RW-1:0]     rd_addr,
    input  logic [ROW_W-1:0]  rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RW-1:0]     out_row,
    output logic [ROW_W-1:0]  out_data,
    output logic [ZW-1:0]     zero_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [RW-1:0]            row_cnt;
    logic                     last_row;
    logic                     start_ok;
    logic                     load_row;
    logic                     advance;
    logic [MATRIX_SIZE_2-1:0] pos_mask;
    logic [ROW_W-1:0]         relu_row;

    assign last_row  = (row_cnt == RW'(MATRIX_SIZE_1 - 1));
    // abort always wins over start, a pending row load, or a handshake
    assign start_ok  = (state == ST_IDLE) && start && !abort;
    assign load_row  = (state == ST_WAIT) && !abort;
    assign advance   = (state == ST_SEND) && out_ready && !abort && !last_row;

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign rd_en     = (state == ST_FETCH);
    assign rd_addr   = row_cnt;
    assign out_valid = (state == ST_SEND);

    // Element is kept only when strictly positive: sign bit clear and not zero
    always_comb begin
        pos_mask = '0;
        relu_row = '0;
        for (int j = 0; j < MATRIX_SIZE_2; j++) begin
            pos_mask[j] = !rd_data[j*DATA_WIDTH + DATA_WIDTH - 1] &&
                          (rd_data[j*DATA_WIDTH +: DATA_WIDTH] != '0);
            if (pos_mask[j]) begin
                relu_row[j*DATA_WIDTH +: DATA_WIDTH] = rd_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort returns to IDLE from any busy state without a done pulse
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = abort ? ST_IDLE : ST_WAIT;
            ST_WAIT:  state_nxt = abort ? ST_IDLE : ST_SEND;
            ST_SEND: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (out_ready) begin
                    state_nxt = last_row ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Row counter: cleared on accepted start, stepped on each non-final handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt <= '0;
        end else if (start_ok) begin
            row_cnt <= '0;
        end else if (advance) begin
            row_cnt <= row_cnt + RW'(1);
        end
    end

    // Output row register, loaded from the buffer in the cycle its data is valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_row  <= '0;
        end else if (load_row) begin
            out_data <= relu_row;
            out_row  <= row_cnt;
        end
    end

`ifdef RELU_ROW_SCHED_ZCNT_EN
    logic [ZW-1:0] row_zeros;

    // Number of clamped elements in the row currently on rd_data
    always_comb begin
        row_zeros = '0;
        for (int j = 0; j < MATRIX_SIZE_2; j++) begin
            if (!pos_mask[j]) begin
                row_zeros = row_zeros + ZW'(1);
            end
        end
    end

    // Pass-level clamp counter; the width covers a full matrix so it never wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_cnt <= '0;
        end else if (start_ok) begin
            zero_cnt <= '0;
        end else if (load_row) begin
            zero_cnt <= zero_cnt + row_zeros;
        end
    end
`else
    assign zero_cnt = '0;
`endif

endmodule
